// File: rtl/instr_fetch.sv
// Fetch stage: owns the program counter, drives the combinational instruction
// ROM address and registers the returned word for decode. Handles start/halt
// sequencing, downstream stall and taken-branch redirect with a one-bubble
// squash of the word fetched in the redirect cycle.
module instr_fetch #(
    parameter int             A          = 4,
    parameter int             W          = 9,
    parameter logic [W-1:0]   HALT_INSTR = 9'h1FF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [A-1:0] start_addr,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [A-1:0] branch_target,
    output logic [A-1:0] inst_addr,
    input  logic [W-1:0] inst_in,
    output logic [W-1:0] instr_out,
    output logic [A-1:0] instr_pc,
    output logic         instr_valid,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [A-1:0] PC_LAST = {A{1'b1}};

    state_t       state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [W-1:0] instr_q, instr_d;
    logic [A-1:0] ipc_q, ipc_d;
    logic         valid_q, valid_d;

    // The ROM address is the PC itself; the ROM answers within the cycle.
    assign inst_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign done        = (state_q == S_HALT);

    // Next-state: start beats stall, stall beats branch, branch beats sequential fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;

        if (start) begin
            // Restart drops whatever was in flight.
            state_d = S_RUN;
            pc_d    = start_addr;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stall) begin
                        // Freeze everything; a branch seen now is re-presented later.
                    end else if (branch_taken) begin
                        // Word fetched this cycle is squashed, halt encoding included.
                        pc_d    = branch_target;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = inst_in;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        if (inst_in == HALT_INSTR) begin
                            state_d = S_HALT;
                        end else if (pc_q == PC_LAST) begin
                            // Top of ROM: stop rather than wrap to address 0.
                            state_d = S_HALT;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
                default: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

endmodule
